gs_div_ctrl: RTL and testbench



---
 rtl/gs_ctrl_pkg.sv | 15 +
 rtl/gs_step_timer.sv | 30 +++
 rtl/gs_div_ctrl.sv | 115 +++++++++++
 tb/tb_gs_div_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gs_ctrl_pkg.sv
// Shared types and encodings for the Goldschmidt divider sequencer.
package gs_ctrl_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, SEED, ITER, DONE} gs_state_t;

  localparam logic [1:0] SEL_IN = 2'b00;
  localparam logic [1:0] SEL_IA = 2'b01;
  localparam logic [1:0] SEL_K  = 2'b10;

  localparam logic K_IA  = 1'b0;
  localparam logic K_2MD = 1'b1;

  localparam int STEP_W = 4;

endpackage

// File: rtl/gs_step_timer.sv
// Multiply hold timer: counts MUL_LAT cycles per step and flags the last one.
module gs_step_timer
  import gs_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  output logic step_fire
);

  localparam int HOLD_W = $clog2(MUL_LAT + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MUL_LAT - 1);

  logic [HOLD_W-1:0] hold_q;

  assign step_fire = active && (hold_q == HOLD_LAST);

  // Every state/step change coincides with step_fire, so clearing on it restarts each window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      hold_q <= '0;
    else if (!active || step_fire)
      hold_q <= '0;
    else
      hold_q <= hold_q + 1'b1;
  end

endmodule

// File: rtl/gs_div_ctrl.sv
// Goldschmidt divider sequencer: LOAD, IA seed, ITERATIONS x (2 - D) steps, DONE.
// Optional early exit on d_converged when GS_EARLY_EXIT_EN is defined.
//
// state | meaning
// IDLE  | ready, waiting for start
// LOAD  | external N/D written into the registers
// SEED  | N/D times IA, held MUL_LAT cycles
// ITER  | N/D times (2 - D), one MUL_LAT window per step
// DONE  | one-cycle quotient capture / done pulse
module gs_div_ctrl
  import gs_ctrl_pkg::*;
#(
  parameter int ITERATIONS = 4,
  parameter int MUL_LAT    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              ready,
  output logic [1:0]        sel_ND_mux,
  output logic              sel_K_mux,
  output logic              load_regN,
  output logic              load_regD,
  output logic              load_result,
  output logic              done,
  output logic [STEP_W-1:0] busy_step
`ifdef GS_EARLY_EXIT_EN
  ,
  input  logic              d_converged
`endif
);

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(ITERATIONS - 1);

  gs_state_t         state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              step_fire;
  logic              timer_active;
  logic              exit_iter;

  assign timer_active = (state_q == SEED) || (state_q == ITER);

  gs_step_timer #(.MUL_LAT(MUL_LAT)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .active    (timer_active),
    .step_fire (step_fire)
  );

`ifdef GS_EARLY_EXIT_EN
  assign exit_iter = (step_q == LAST_STEP) || d_converged;
`else
  assign exit_iter = (step_q == LAST_STEP);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    ready       = 1'b0;
    sel_ND_mux  = SEL_IN;
    sel_K_mux   = K_IA;
    load_regN   = 1'b0;
    load_result = 1'b0;
    done        = 1'b0;
    busy_step   = '0;
    unique case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start) state_d = LOAD;
      end
      LOAD: begin
        load_regN = 1'b1;
        state_d   = SEED;
      end
      SEED: begin
        sel_ND_mux = SEL_IA;
        load_regN  = step_fire;
        if (step_fire) state_d = ITER;
      end
      ITER: begin
        sel_ND_mux = SEL_K;
        sel_K_mux  = K_2MD;
        load_regN  = step_fire;
        busy_step  = step_q;
        if (step_fire) begin
          if (exit_iter) state_d = DONE;
          else           step_d  = step_q + 1'b1;
        end
      end
      DONE: begin
        sel_ND_mux  = SEL_K;
        sel_K_mux   = K_2MD;
        load_result = 1'b1;
        done        = 1'b1;
        step_d      = '0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // N and D always advance together.
  assign load_regD = load_regN;

endmodule

// File: tb/tb_gs_div_ctrl.sv
// Scoreboard bench for gs_div_ctrl: three parameterisations share clock and reset.
module tb_gs_div_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic st_a = 1'b0, st_b = 1'b0, st_c = 1'b0;
  int   cyc = 0;
  int   n_tests = 0, n_fail = 0;
  int   done_cnt_a = 0, done_cnt_b = 0, done_cnt_c = 0;
  int   q_a[$], q_b[$], q_c[$];

  logic       ready_a, sel_k_a, ldn_a, ldd_a, res_a, done_a;
  logic [1:0] sel_nd_a;
  logic [3:0] step_a;
  logic       ready_b, sel_k_b, ldn_b, ldd_b, res_b, done_b;
  logic [1:0] sel_nd_b;
  logic [3:0] step_b;
  logic       ready_c, sel_k_c, ldn_c, ldd_c, res_c, done_c;
  logic [1:0] sel_nd_c;
  logic [3:0] step_c;
`ifdef GS_EARLY_EXIT_EN
  logic dconv = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gs_div_ctrl #(.ITERATIONS(4), .MUL_LAT(1)) dut_a (
    .clk(clk), .reset(reset), .start(st_a), .ready(ready_a), .sel_ND_mux(sel_nd_a),
    .sel_K_mux(sel_k_a), .load_regN(ldn_a), .load_regD(ldd_a), .load_result(res_a),
    .done(done_a), .busy_step(step_a)
`ifdef GS_EARLY_EXIT_EN
    , .d_converged(dconv)
`endif
  );

  gs_div_ctrl #(.ITERATIONS(4), .MUL_LAT(3)) dut_b (
    .clk(clk), .reset(reset), .start(st_b), .ready(ready_b), .sel_ND_mux(sel_nd_b),
    .sel_K_mux(sel_k_b), .load_regN(ldn_b), .load_regD(ldd_b), .load_result(res_b),
    .done(done_b), .busy_step(step_b)
`ifdef GS_EARLY_EXIT_EN
    , .d_converged(1'b0)
`endif
  );

  gs_div_ctrl #(.ITERATIONS(1), .MUL_LAT(1)) dut_c (
    .clk(clk), .reset(reset), .start(st_c), .ready(ready_c), .sel_ND_mux(sel_nd_c),
    .sel_K_mux(sel_k_c), .load_regN(ldn_c), .load_regD(ldd_c), .load_result(res_c),
    .done(done_c), .busy_step(step_c)
`ifdef GS_EARLY_EXIT_EN
    , .d_converged(1'b0)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // {ready, sel_ND[1:0], sel_K, ldN, ldD, result, done, step[3:0]}
  function automatic logic [11:0] obs_of(input int w);
    case (w)
      0:       return {ready_a, sel_nd_a, sel_k_a, ldn_a, ldd_a, res_a, done_a, step_a};
      1:       return {ready_b, sel_nd_b, sel_k_b, ldn_b, ldd_b, res_b, done_b, step_b};
      default: return {ready_c, sel_nd_c, sel_k_c, ldn_c, ldd_c, res_c, done_c, step_c};
    endcase
  endfunction

  // Expected outputs k cycles after the edge that sampled start (k = 1 is LOAD).
  function automatic logic [11:0] model(input int k, input int it, input int ml);
    int dk;
    int j;
    logic ld;
    logic [11:0] v;
    dk = 2 + (it + 1) * ml;
    v  = 12'h800;
    if (k == 1)
      v = {1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0};
    else if (k >= 2 && k <= 1 + ml) begin
      ld = (k == 1 + ml);
      v  = {1'b0, 2'b01, 1'b0, ld, ld, 1'b0, 1'b0, 4'd0};
    end else if (k >= 2 + ml && k < dk) begin
      j  = k - 2 - ml;
      ld = ((j % ml) == ml - 1);
      v  = {1'b0, 2'b10, 1'b1, ld, ld, 1'b0, 1'b0, 4'(j / ml)};
    end else if (k == dk)
      v = {1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0};
    return v;
  endfunction

  task automatic set_start(input int w, input logic v);
    case (w)
      0:       st_a = v;
      1:       st_b = v;
      default: st_c = v;
    endcase
  endtask

  task automatic push(input int w, input int c);
    case (w)
      0:       q_a.push_back(c);
      1:       q_b.push_back(c);
      default: q_c.push_back(c);
    endcase
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Full sequence with per-cycle comparison; sel_K is a don't-care during DONE.
  task automatic run_seq(input int w, input int it, input int ml);
    int dk;
    logic [11:0] m;
    dk = 2 + (it + 1) * ml;
    @(negedge clk);
    set_start(w, 1'b1);
    push(w, cyc + dk);
    for (int k = 1; k <= dk + 1; k++) begin
      @(negedge clk);
      if (k == 1) set_start(w, 1'b0);
      m = (k == dk) ? 12'hEFF : 12'hFFF;
      chk($sformatf("seq_w%0d_k%0d", w, k), 32'(obs_of(w) & m), 32'(model(k, it, ml) & m));
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (done_a) begin
        done_cnt_a++;
        if (q_a.size() == 0) chk("done_a_unexp", cyc, 32'hFFFF_FFFF);
        else                 chk("done_a_cyc", cyc, q_a.pop_front());
      end
      if (done_b) begin
        done_cnt_b++;
        if (q_b.size() == 0) chk("done_b_unexp", cyc, 32'hFFFF_FFFF);
        else                 chk("done_b_cyc", cyc, q_b.pop_front());
      end
      if (done_c) begin
        done_cnt_c++;
        if (q_c.size() == 0) chk("done_c_unexp", cyc, 32'hFFFF_FFFF);
        else                 chk("done_c_cyc", cyc, q_c.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    repeat (3) @(negedge clk);
    chk("rst_a", 32'(obs_of(0)), 32'h800);
    chk("rst_b", 32'(obs_of(1)), 32'h800);
    chk("rst_c", 32'(obs_of(2)), 32'h800);
    reset = 1'b1;

    // Reset mid-ITER at step 2: no done may be reported for the aborted run.
    @(negedge clk);
    c0 = cyc;
    st_a = 1'b1;
    wait_to(c0 + 1);
    st_a = 1'b0;
    wait_to(c0 + 5);
    chk("pre_rst_step", 32'(step_a), 32'd2);
    reset = 1'b0;
    #1;
    chk("mid_rst_outputs", 32'(obs_of(0)), 32'h800);
    @(negedge clk);
    reset = 1'b1;

    run_seq(0, 4, 1);
    run_seq(1, 4, 3);
    run_seq(2, 1, 1);

    // Start pulses during ITER (cycle 3) and DONE (cycle 7) are dropped.
    @(negedge clk);
    c0 = cyc;
    st_a = 1'b1;
    q_a.push_back(c0 + 7);
    wait_to(c0 + 1); st_a = 1'b0;
    wait_to(c0 + 3); st_a = 1'b1;
    wait_to(c0 + 4); st_a = 1'b0;
    wait_to(c0 + 7); st_a = 1'b1;
    wait_to(c0 + 8); st_a = 1'b0;
    wait_to(c0 + 20);
    chk("ignore_q_empty", q_a.size(), 0);
    chk("ignore_ready", 32'(ready_a), 32'd1);

    // Start held high: back-to-back runs with one IDLE gap.
    c0 = cyc;
    st_a = 1'b1;
    q_a.push_back(c0 + 7);
    q_a.push_back(c0 + 15);
    wait_to(c0 + 8);
    chk("b2b_gap_ready", 32'(ready_a), 32'd1);
    wait_to(c0 + 15);
    st_a = 1'b0;
    wait_to(c0 + 20);
    chk("b2b_q_empty", q_a.size(), 0);

`ifdef GS_EARLY_EXIT_EN
    c0 = cyc;
    st_a = 1'b1;
    q_a.push_back(c0 + 5);
    wait_to(c0 + 1); st_a = 1'b0;
    wait_to(c0 + 3);
    chk("ee_step0_load", 32'({ldn_a, step_a}), 32'h10);
    wait_to(c0 + 4);
    chk("ee_step1_load", 32'({ldn_a, step_a}), 32'h11);
    dconv = 1'b1;
    wait_to(c0 + 5);
    dconv = 1'b0;
    chk("ee_done", 32'(done_a), 32'd1);
    wait_to(c0 + 8);
    chk("ee_q_empty", q_a.size(), 0);
`endif

    repeat (3) @(negedge clk);
    chk("final_q_a", q_a.size(), 0);
    chk("final_q_b", q_b.size(), 0);
    chk("final_q_c", q_c.size(), 0);
`ifdef GS_EARLY_EXIT_EN
    chk("final_dones_a", done_cnt_a, 5);
`else
    chk("final_dones_a", done_cnt_a, 4);
`endif
    chk("final_dones_b", done_cnt_b, 1);
    chk("final_dones_c", done_cnt_c, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
